// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// The memory answers combinationally: imem_data is the word at imem_addr
// in the same cycle.
interface fetch_stage_if;
   logic [15:0] imem_addr;
   logic        imem_rd;
   logic [15:0] imem_data;

   // Fetch stage side: drives address and read enable, receives data
   modport master (
      output imem_addr,
      output imem_rd,
      input  imem_data
   );

   // Memory side: observes address and read enable, returns data
   modport slave (
      input  imem_addr,
      input  imem_rd,
      output imem_data
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 16-bit CPU pipeline.
// It owns the PC and drives the instruction-memory address. Fetched words
// are registered into the IF/ID register. The stage handles hazard stalls,
// taken-branch flushes and HLT detection.
// Edge priority is branch > stall > normal fetch.
// Optional macro FETCH_PERF_CNT_EN adds two counters: fetch_count counts
// real fetches into IF/ID, and flush_count counts cycles with branch
// asserted.
module fetch_stage #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] NOP_INSTR   = 16'hA000,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                branch,
   input  logic [15:0]         target_pc,
   fetch_stage_if.master       imem,
   output logic [15:0]         pc,
   output logic [15:0]         ifid_instr,
   output logic [15:0]         ifid_pc_plus_two,
   output logic                ifid_valid,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]         fetch_count,
   output logic [15:0]         flush_count,
`endif
   output logic                halted
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ifid_instr_q, ifid_instr_d;
   logic [15:0] ifid_ppt_q, ifid_ppt_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [15:0] pc_inc;
   logic        is_hlt;
   logic        load_fetch;

   // Wraps from 16'hFFFE to 16'h0000 without any indication
   assign pc_inc = pc_q + 16'd2;
   assign is_hlt = (imem.imem_data[15:12] == HALT_OPCODE);

   // A real fetch into IF/ID happens only when running, not stalled and
   // not redirected
   assign load_fetch = !branch && !stall && (state_q == RUN);

   // State register, PC and IF/ID register; reset discards everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         ifid_instr_q <= NOP_INSTR;
         ifid_ppt_q   <= 16'h0000;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_ppt_q   <= ifid_ppt_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   // Next-state logic: the branch redirect wins, a stall freezes the stage,
   // and otherwise the stage fetches (RUN) or injects bubbles (HALTED)
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_ppt_d   = ifid_ppt_q;
      ifid_valid_d = ifid_valid_q;

      if (branch) begin
         // The word on imem_data is wrong-path, even if it is HLT, so drop it
         pc_d         = target_pc;
         ifid_instr_d = NOP_INSTR;
         ifid_ppt_d   = 16'h0000;
         ifid_valid_d = 1'b0;
         state_d      = RUN;
      end else if (stall) begin
         // Hold everything
      end else if (state_q == RUN) begin
         ifid_instr_d = imem.imem_data;
         ifid_ppt_d   = pc_inc;
         ifid_valid_d = 1'b1;
         if (is_hlt) begin
            // Park the PC on the HLT itself
            state_d = HALTED;
         end else begin
            pc_d = pc_inc;
         end
      end else begin
         // Halted: keep the PC and feed bubbles until a branch or reset
         ifid_instr_d = NOP_INSTR;
         ifid_ppt_d   = 16'h0000;
         ifid_valid_d = 1'b0;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q;
   logic [15:0] flush_count_q;

   // Performance counters, free-running and wrapping at their width
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count_q <= 32'd0;
         flush_count_q <= 16'd0;
      end else begin
         if (load_fetch) begin
            fetch_count_q <= fetch_count_q + 32'd1;
         end
         if (branch) begin
            flush_count_q <= flush_count_q + 16'd1;
         end
      end
   end

   assign fetch_count = fetch_count_q;
   assign flush_count = flush_count_q;
`endif

   // The read enable drops at once while reset is asserted
   assign imem.imem_rd    = rst_n && (state_q == RUN) && !stall;
   assign imem.imem_addr  = pc_q;
   assign pc               = pc_q;
   assign ifid_instr       = ifid_instr_q;
   assign ifid_pc_plus_two = ifid_ppt_q;
   assign ifid_valid       = ifid_valid_q;
   assign halted           = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. The stimulus process drives one cycle
// at each falling edge. It steps a behavioural model of the fetch rules
// and pushes the expected post-edge state into a queue. A monitor pops one
// entry after each rising edge and compares it with the DUT outputs.
`timescale 1ns/100ps
module tb_fetch_stage;

   localparam logic [15:0] NOP = 16'hA000;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        branch;
   logic [15:0] target_pc;
   logic [15:0] pc;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc_plus_two;
   logic        ifid_valid;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [15:0] flush_count;
`endif

   fetch_stage_if bus ();

   fetch_stage dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall            (stall),
      .branch           (branch),
      .target_pc        (target_pc),
      .imem             (bus),
      .pc               (pc),
      .ifid_instr       (ifid_instr),
      .ifid_pc_plus_two (ifid_pc_plus_two),
      .ifid_valid       (ifid_valid),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count      (fetch_count),
      .flush_count      (flush_count),
`endif
      .halted           (halted)
   );

   // Byte-addressed instruction memory holding one 16-bit word per even address
   logic [15:0] mem [0:32767];
   assign bus.imem_data = mem[bus.imem_addr[15:1]];

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   typedef struct {
      logic [15:0] pc;
      logic [15:0] instr;
      logic [15:0] ppt;
      logic        valid;
      logic        halted;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [15:0] m_pc;
   logic [15:0] m_instr;
   logic [15:0] m_ppt;
   logic        m_valid;
   logic        m_halted;
   int unsigned m_fetches;
   int unsigned m_flushes;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 16'h0000;
      m_instr   = NOP;
      m_ppt     = 16'h0000;
      m_valid   = 1'b0;
      m_halted  = 1'b0;
      m_fetches = 0;
      m_flushes = 0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_pc"},     32'(pc), 32'h0000);
      chk({tag, "_instr"},  32'(ifid_instr), 32'(NOP));
      chk({tag, "_ppt"},    32'(ifid_pc_plus_two), 32'h0000);
      chk({tag, "_valid"},  32'(ifid_valid), 32'h0);
      chk({tag, "_halted"}, 32'(halted), 32'h0);
      chk({tag, "_imemrd"}, 32'(bus.imem_rd), 32'h0);
   endtask

   // One pipeline cycle: drive inputs, check the combinational bus outputs,
   // then predict the state that follows the next rising edge
   task automatic cycle(input logic s, input logic b, input logic [15:0] t);
      exp_t        e;
      logic [15:0] word;
      @(negedge clk);
      stall     = s;
      branch    = b;
      target_pc = t;
      #1;
      chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      chk("imem_rd",   32'(bus.imem_rd), 32'(!m_halted && !s));
      if (b) begin
         m_pc     = t;
         m_instr  = NOP;
         m_ppt    = 16'h0000;
         m_valid  = 1'b0;
         m_halted = 1'b0;
         m_flushes++;
      end else if (!s) begin
         if (!m_halted) begin
            word    = mem[m_pc / 2];
            m_instr = word;
            m_ppt   = 16'(m_pc + 16'd2);
            m_valid = 1'b1;
            m_fetches++;
            if (word[15:12] == 4'hF) m_halted = 1'b1;
            else                     m_pc = 16'(m_pc + 16'd2);
         end else begin
            m_instr = NOP;
            m_ppt   = 16'h0000;
            m_valid = 1'b0;
         end
      end
      e.pc     = m_pc;
      e.instr  = m_instr;
      e.ppt    = m_ppt;
      e.valid  = m_valid;
      e.halted = m_halted;
      exp_q.push_back(e);
      $display("cycle stall=%0b branch=%0b target=%h -> exp pc=%h instr=%h ppt=%h valid=%0b halted=%0b",
               s, b, t, e.pc, e.instr, e.ppt, e.valid, e.halted);
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear at once
   task automatic reset_pulse();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      model_reset();
      #2;
      rst_n = 1'b1;
      $display("async reset pulse applied");
   endtask

   // Scoreboard monitor: compare the DUT state after every rising edge
   // that has a prediction waiting
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("pc",         32'(pc), 32'(mon_e.pc));
         chk("ifid_instr", 32'(ifid_instr), 32'(mon_e.instr));
         chk("ifid_ppt",   32'(ifid_pc_plus_two), 32'(mon_e.ppt));
         chk("ifid_valid", 32'(ifid_valid), 32'(mon_e.valid));
         chk("halted",     32'(halted), 32'(mon_e.halted));
      end
   end

   initial begin
      logic [15:0] w;
      logic        s, b;
      logic [15:0] t;

      // Random program without HLT in the low region; HLT is sprinkled
      // sparsely above 16'h0400
      for (int i = 0; i < 32768; i++) begin
         w = 16'($urandom);
         if (w[15:12] == 4'hF) w[15:12] = 4'h1;
         if (i >= 16'h0200 && $urandom_range(0, 11) == 0) w[15:12] = 4'hF;
         mem[i] = w;
      end
      mem[16'h0000 >> 1] = 16'h1234;
      mem[16'h0002 >> 1] = 16'h5678;
      mem[16'h0030 >> 1] = 16'hF000;
      mem[16'hFFFE >> 1] = 16'h2222;

      stall     = 1'b0;
      branch    = 1'b0;
      target_pc = 16'h0000;
      rst_n     = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #4;
      check_reset_values("reset");
      #2;
      rst_n = 1'b1;

      // Straight-line fetch from the reset PC
      cycle(0, 0, 16'h0000);
      cycle(0, 0, 16'h0000);
      // Three-cycle stall at 16'h0010, then resume
      cycle(0, 1, 16'h0010);
      repeat (3) cycle(1, 0, 16'h0000);
      cycle(0, 0, 16'h0000);
      // Branch together with stall: the redirect still happens
      cycle(0, 1, 16'h0020);
      cycle(1, 1, 16'h0100);
      cycle(0, 0, 16'h0000);
      // HLT at 16'h0030, bubbles while halted, branch out to 16'h0040
      cycle(0, 1, 16'h0030);
      cycle(0, 0, 16'h0000);
      cycle(0, 0, 16'h0000);
      cycle(1, 0, 16'h0000);
      cycle(0, 0, 16'h0000);
      cycle(0, 1, 16'h0040);
      cycle(0, 0, 16'h0000);
      // HLT on the bus in the same cycle as a branch is discarded
      cycle(0, 1, 16'h0030);
      cycle(0, 1, 16'h0050);
      cycle(0, 0, 16'h0000);
      // PC wrap at the top of the address space
      cycle(0, 1, 16'hFFFE);
      cycle(0, 0, 16'h0000);
      cycle(0, 0, 16'h0000);
      // Reset in the middle of fetching
      reset_pulse();
      cycle(0, 0, 16'h0000);
      cycle(0, 0, 16'h0000);

      // Randomised traffic; leave the halted state more often by branching
      for (int n = 0; n < 600; n++) begin
         s = ($urandom_range(0, 3) == 0);
         b = m_halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         t = 16'($urandom_range(0, 32767)) << 1;
         cycle(s, b, t);
         if (n == 300) reset_pulse();
      end

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, 32'(m_fetches));
      chk("flush_count", 32'(flush_count), 32'(16'(m_flushes)));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
